prod_resp_checker: RTL and testbench

- Parametrised relational checker for the self-composed product circuit.
- Compares NCH debug-port response streams between the Left and Right copies. Example channels: source and target cores.
- Tolerates up to DEPTH responses of skew between the copies. It buffers the leading side per channel and compares when the lagging side catches up.
- Raises sticky mismatch and overflow flags for the product's verification conditions, plus a quiescence indication for invariant checks.

---
 rtl/prod_pkg.sv | 17 +
 rtl/prod_skew_fifo.sv | 68 ++++++
 rtl/prod_resp_checker.sv | 157 +++++++++++++++
 tb/tb_prod_resp_checker.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prod_pkg.sv
// Shared types and helpers for the Left/Right product response checker.
package prod_pkg;

  typedef enum logic [1:0] {
    LEAD_NONE  = 2'd0,
    LEAD_LEFT  = 2'd1,
    LEAD_RIGHT = 2'd2
  } lead_e;

  localparam int unsigned CNT_W_DFLT = 16;

  // Bit offset of channel ch inside a packed multi-channel data bus.
  function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned w);
    return ch * w;
  endfunction

endpackage

// File: rtl/prod_skew_fifo.sv
// Circular buffer holding the leading side's responses for one channel.
module prod_skew_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] occ
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (occ_q == OCC_W'(DEPTH));
  assign empty = (occ_q == '0);
  assign occ   = occ_q;

endmodule

// File: rtl/prod_resp_checker.sv
// Relational checker comparing Left/Right response streams per channel with bounded skew.
module prod_resp_checker
  import prod_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NCH    = 2,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = CNT_W_DFLT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  strict,
  input  logic [NCH-1:0]        valid_left,
  input  logic [NCH*DATA_W-1:0] data_left,
  input  logic [NCH-1:0]        valid_right,
  input  logic [NCH*DATA_W-1:0] data_right,
  output logic                  mismatch,
  output logic [NCH-1:0]        mismatch_ch,
  output logic [NCH-1:0]        overflow_ch,
  output logic                  in_sync,
  output logic [CNT_W-1:0]      cmp_count
);

  localparam int OCC_W  = $clog2(DEPTH + 1);
  localparam int NSUM_W = $clog2(NCH + 1);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  lead_e             lead_q [NCH];
  lead_e             lead_d [NCH];
  logic [NCH-1:0]    push, pop, full, empty, cmp_done, mis_ev, ovf_ev;
  logic [DATA_W-1:0] push_data [NCH];
  logic [DATA_W-1:0] head [NCH];
  logic [OCC_W-1:0]  occ [NCH];
  logic [NCH-1:0]    mismatch_ch_q, mismatch_ch_d, overflow_ch_q, overflow_ch_d;
  logic [CNT_W-1:0]  cmp_count_q, cmp_count_d;
  logic [NSUM_W-1:0] n_cmp;
  logic [CNT_W:0]    cnt_sum;
  logic [DATA_W-1:0] dl, dr;

  for (genvar g = 0; g < NCH; g++) begin : g_fifo
    prod_skew_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push[g]),
      .push_data (push_data[g]),
      .pop       (pop[g]),
      .head      (head[g]),
      .full      (full[g]),
      .empty     (empty[g]),
      .occ       (occ[g])
    );
  end

  always_comb begin
    push     = '0;
    pop      = '0;
    cmp_done = '0;
    mis_ev   = '0;
    ovf_ev   = '0;
    dl       = '0;
    dr       = '0;
    for (int c = 0; c < NCH; c++) begin
      lead_d[c]    = lead_q[c];
      dl           = data_left[ch_lsb(c, DATA_W) +: DATA_W];
      dr           = data_right[ch_lsb(c, DATA_W) +: DATA_W];
      push_data[c] = dl;
      if (strict) begin
        if (valid_left[c] && valid_right[c]) begin
          cmp_done[c] = 1'b1;
          mis_ev[c]   = (dl != dr);
        end else if (valid_left[c] || valid_right[c]) begin
          mis_ev[c] = 1'b1;
        end
      end else begin
        case (lead_q[c])
          LEAD_LEFT: begin
            if (valid_right[c]) begin
              pop[c]      = 1'b1;
              cmp_done[c] = 1'b1;
              mis_ev[c]   = (head[c] != dr);
              if (valid_left[c]) push[c] = 1'b1;
              else if (occ[c] == OCC_W'(1)) lead_d[c] = LEAD_NONE;
            end else if (valid_left[c]) begin
              if (full[c]) begin
                ovf_ev[c] = 1'b1;
                mis_ev[c] = 1'b1;
              end else begin
                push[c] = 1'b1;
              end
            end
          end
          LEAD_RIGHT: begin
            push_data[c] = dr;
            if (valid_left[c]) begin
              pop[c]      = 1'b1;
              cmp_done[c] = 1'b1;
              mis_ev[c]   = (head[c] != dl);
              if (valid_right[c]) push[c] = 1'b1;
              else if (occ[c] == OCC_W'(1)) lead_d[c] = LEAD_NONE;
            end else if (valid_right[c]) begin
              if (full[c]) begin
                ovf_ev[c] = 1'b1;
                mis_ev[c] = 1'b1;
              end else begin
                push[c] = 1'b1;
              end
            end
          end
          default: begin
            if (valid_left[c] && valid_right[c]) begin
              cmp_done[c] = 1'b1;
              mis_ev[c]   = (dl != dr);
            end else if (valid_left[c]) begin
              push[c]   = 1'b1;
              lead_d[c] = LEAD_LEFT;
            end else if (valid_right[c]) begin
              push[c]      = 1'b1;
              push_data[c] = dr;
              lead_d[c]    = LEAD_RIGHT;
            end
          end
        endcase
      end
    end
  end

  // Saturating add: the carry out of the widened sum means we passed the maximum.
  always_comb begin
    n_cmp = '0;
    for (int c = 0; c < NCH; c++) n_cmp = n_cmp + NSUM_W'(cmp_done[c]);
    cnt_sum       = {1'b0, cmp_count_q} + (CNT_W + 1)'(n_cmp);
    cmp_count_d   = cnt_sum[CNT_W] ? CNT_SAT : cnt_sum[CNT_W-1:0];
    mismatch_ch_d = mismatch_ch_q | mis_ev;
    overflow_ch_d = overflow_ch_q | ovf_ev;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mismatch_ch_q <= '0;
      overflow_ch_q <= '0;
      cmp_count_q   <= '0;
      for (int c = 0; c < NCH; c++) lead_q[c] <= LEAD_NONE;
    end else begin
      mismatch_ch_q <= mismatch_ch_d;
      overflow_ch_q <= overflow_ch_d;
      cmp_count_q   <= cmp_count_d;
      for (int c = 0; c < NCH; c++) lead_q[c] <= lead_d[c];
    end
  end

  assign mismatch    = |mismatch_ch_q;
  assign mismatch_ch = mismatch_ch_q;
  assign overflow_ch = overflow_ch_q;
  assign in_sync     = &empty;
  assign cmp_count   = cmp_count_q;

endmodule

// File: tb/tb_prod_resp_checker.sv
// Directed plus randomized bench for prod_resp_checker against a two-queue reference model.
module tb_prod_resp_checker;

  localparam int DW    = 32;
  localparam int NCH   = 2;
  localparam int DEPTH = 4;
  localparam int CW    = 4;
  localparam int CSAT  = (1 << CW) - 1;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 strict;
  logic [NCH-1:0]       valid_left, valid_right;
  logic [NCH*DW-1:0]    data_left, data_right;
  logic                 mismatch;
  logic [NCH-1:0]       mismatch_ch, overflow_ch;
  logic                 in_sync;
  logic [CW-1:0]        cmp_count;

  prod_resp_checker #(.DATA_W(DW), .NCH(NCH), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clock       (clock),
    .reset       (reset),
    .strict      (strict),
    .valid_left  (valid_left),
    .data_left   (data_left),
    .valid_right (valid_right),
    .data_right  (data_right),
    .mismatch    (mismatch),
    .mismatch_ch (mismatch_ch),
    .overflow_ch (overflow_ch),
    .in_sync     (in_sync),
    .cmp_count   (cmp_count)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: unmatched words of each side per channel; matching pairs the queue heads.
  logic [DW-1:0]  ql [NCH][$];
  logic [DW-1:0]  qr [NCH][$];
  logic [NCH-1:0] m_mis, m_ovf;
  int             m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int inc;
    logic [DW-1:0] a, b, dlc, drc;
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        ql[c].delete();
        qr[c].delete();
      end
      m_mis = '0;
      m_ovf = '0;
      m_cnt = 0;
      return;
    end
    inc = 0;
    for (int c = 0; c < NCH; c++) begin
      dlc = data_left[c*DW +: DW];
      drc = data_right[c*DW +: DW];
      if (strict) begin
        if (valid_left[c] && valid_right[c]) begin
          inc++;
          if (dlc != drc) m_mis[c] = 1'b1;
        end else if (valid_left[c] || valid_right[c]) begin
          m_mis[c] = 1'b1;
        end
      end else begin
        if (valid_left[c]) begin
          if (!valid_right[c] && ql[c].size() == DEPTH) begin
            m_ovf[c] = 1'b1;
            m_mis[c] = 1'b1;
          end else ql[c].push_back(dlc);
        end
        if (valid_right[c]) begin
          if (!valid_left[c] && qr[c].size() == DEPTH) begin
            m_ovf[c] = 1'b1;
            m_mis[c] = 1'b1;
          end else qr[c].push_back(drc);
        end
        while (ql[c].size() > 0 && qr[c].size() > 0) begin
          a = ql[c].pop_front();
          b = qr[c].pop_front();
          inc++;
          if (a != b) m_mis[c] = 1'b1;
        end
      end
    end
    m_cnt = (m_cnt + inc > CSAT) ? CSAT : m_cnt + inc;
  endtask

  function automatic logic model_sync();
    for (int c = 0; c < NCH; c++)
      if (ql[c].size() != 0 || qr[c].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".mismatch_ch"}, 32'(mismatch_ch), 32'(m_mis));
    chk({tag, ".overflow_ch"}, 32'(overflow_ch), 32'(m_ovf));
    chk({tag, ".mismatch"},    32'(mismatch),    32'(|m_mis));
    chk({tag, ".in_sync"},     32'(in_sync),     32'(model_sync()));
    chk({tag, ".cmp_count"},   32'(cmp_count),   32'(m_cnt));
  endtask

  task automatic step(input string tag,
                      input logic [NCH-1:0] vl, input logic [NCH*DW-1:0] dl,
                      input logic [NCH-1:0] vr, input logic [NCH*DW-1:0] dr);
    valid_left  = vl;
    data_left   = dl;
    valid_right = vr;
    data_right  = dr;
    @(posedge clock);
    #1;
    model_step();
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, '0, '0, '0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle("reset");
    reset = 1'b0;
  endtask

  function automatic logic [NCH*DW-1:0] pk(input logic [DW-1:0] d1, input logic [DW-1:0] d0);
    return {d1, d0};
  endfunction

  logic [NCH-1:0]    rvl, rvr;
  logic [NCH*DW-1:0] rdl, rdr;
  logic [DW-1:0]     w;
  int                sl [NCH];
  int                sr [NCH];

  initial begin
    reset       = 1'b1;
    strict      = 1'b0;
    valid_left  = '0;
    valid_right = '0;
    data_left   = '0;
    data_right  = '0;
    m_mis = '0;
    m_ovf = '0;
    m_cnt = 0;

    // Reset state
    do_reset();
    chk("rst_in_sync", 32'(in_sync), 32'd1);
    chk("rst_cmp_count", 32'(cmp_count), 32'd0);

    // Lockstep equal on channel 0
    for (int i = 0; i < 3; i++) begin
      step("lockstep", 2'b01, pk(0, 32'hDEADBEEF), 2'b01, pk(0, 32'hDEADBEEF));
      chk("lockstep_sync", 32'(in_sync), 32'd1);
    end
    chk("lockstep_cnt", 32'(cmp_count), 32'd3);
    chk("lockstep_mis", 32'(mismatch), 32'd0);

    // Skew catch-up: Left three cycles ahead
    do_reset();
    for (int i = 0; i < 6; i++) begin
      w = 32'h11 * 32'((i % 3) + 1);
      if (i < 3) step("skew", 2'b01, pk(0, w), 2'b00, '0);
      else       step("skew", 2'b00, '0, 2'b01, pk(0, w));
      chk("skew_sync", 32'(in_sync), (i < 5) ? 32'd0 : 32'd1);
    end
    chk("skew_cnt", 32'(cmp_count), 32'd3);
    chk("skew_mis", 32'(mismatch), 32'd0);

    // Data mismatch with Right leading; flag must stay sticky
    do_reset();
    step("mis", 2'b00, '0, 2'b01, pk(0, 32'hA5));
    idle("mis");
    chk("mis_before", 32'(mismatch_ch), 32'd0);
    step("mis", 2'b01, pk(0, 32'h5A), 2'b00, '0);
    chk("mis_set", 32'(mismatch_ch), 32'b01);
    for (int i = 0; i < 20; i++) begin
      idle("mis_hold");
      chk("mis_sticky", 32'(mismatch_ch), 32'b01);
    end

    // Overflow: five Left words, no Right
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step("ovf", 2'b01, pk(0, 32'(i + 100)), 2'b00, '0);
      chk("ovf_flag", 32'(overflow_ch), (i < 4) ? 32'd0 : 32'b01);
    end
    chk("ovf_mis", 32'(mismatch_ch), 32'b01);
    // Exactly four stored words must drain in order
    for (int i = 0; i < 4; i++) step("ovf_drain", 2'b00, '0, 2'b01, pk(0, 32'(i + 100)));
    chk("ovf_drain_cnt", 32'(cmp_count), 32'd4);
    chk("ovf_drain_sync", 32'(in_sync), 32'd1);

    // Strict ordering violation on channel 1, then reset clears it
    strict = 1'b1;
    do_reset();
    step("strict", 2'b10, pk(32'h77, 0), 2'b00, '0);
    chk("strict_mis", 32'(mismatch_ch), 32'b10);
    chk("strict_cnt", 32'(cmp_count), 32'd0);
    do_reset();
    chk("strict_rst_mis", 32'(mismatch_ch), 32'd0);
    chk("strict_rst_sync", 32'(in_sync), 32'd1);
    strict = 1'b0;
    do_reset();

    // Counter saturation with both channels comparing every cycle
    for (int i = 0; i < 10; i++) begin
      rdl = {$urandom, $urandom};
      step("sat", 2'b11, rdl, 2'b11, rdl);
      chk("sat_cnt", 32'(cmp_count), (2 * (i + 1) > CSAT) ? 32'(CSAT) : 32'(2 * (i + 1)));
    end

    // Randomized segments in both modes with occasional resets and corruptions
    for (int seg = 0; seg < 40; seg++) begin
      strict = ($urandom_range(0, 3) == 0);
      do_reset();
      for (int c = 0; c < NCH; c++) begin
        sl[c] = 0;
        sr[c] = 0;
      end
      for (int cyc = 0; cyc < 16; cyc++) begin
        for (int c = 0; c < NCH; c++) begin
          if (strict) begin
            rvl[c] = ($urandom_range(0, 1) == 1);
            rvr[c] = ($urandom_range(0, 11) == 0) ? ~rvl[c] : rvl[c];
          end else begin
            rvl[c] = (sl[c] - sr[c] >= DEPTH) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
            rvr[c] = (sr[c] - sl[c] >= DEPTH) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
          end
          w = 32'(c * 1000 + sl[c]);
          rdl[c*DW +: DW] = w;
          w = 32'(c * 1000 + sr[c]);
          if ($urandom_range(0, 39) == 0) w = w ^ 32'h1;
          rdr[c*DW +: DW] = w;
          if (rvl[c]) sl[c]++;
          if (rvr[c]) sr[c]++;
        end
        step("rand", rvl, rdl, rvr, rdr);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
